// File: rtl/video_scanout.sv
// video_scanout
//   VGA raster generator with a small pixel FIFO between the PPU and the DAC.
//   One pixel per clock. hpos/vpos are the live beam counters so the PPU can
//   run ahead; display_on/hsync/vsync/rgb are registered and lag them by one
//   clock.
//
// Ports
//   clk             pixel clock
//   reset           asynchronous, active-low
//   pix_valid       PPU offers pix_data
//   pix_data        13-bit pixel colour
//   pix_ready       FIFO accepts the offered pixel this cycle (combinational)
//   hpos, vpos      live horizontal / vertical counters
//   display_on      rgb carries a visible pixel
//   hsync, vsync    active-low sync pulses
//   rgb             pixel to the DAC, 0 outside the active region
//   vblank_start    one-cycle pulse at (hpos 0, vpos V_DISPLAY); FIFO is flushed
//   underflow       sticky: an active pixel was needed while the FIFO was empty
//   clear_underflow synchronous clear of underflow (a new underflow wins)
module video_scanout #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic [15:0]       hpos,
    output logic [15:0]       vpos,
    output logic              display_on,
    output logic              hsync,
    output logic              vsync,
    output logic [DATA_W-1:0] rgb,
    output logic              vblank_start,
    output logic              underflow,
    input  logic              clear_underflow
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS  = 16'(H_DISPLAY);
    localparam logic [15:0] V_VIS  = 16'(V_DISPLAY);
    localparam logic [15:0] HS_BEG = 16'(H_DISPLAY + H_FRONT);
    localparam logic [15:0] HS_END = 16'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_DISPLAY + V_FRONT);
    localparam logic [15:0] VS_END = 16'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [15:0]       hcnt_p0;
    logic [15:0]       vcnt_p0;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              active;
    logic              flush;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              starve;

    logic              vld_p1;
    logic              hsync_p1;
    logic              vsync_p1;
    logic [DATA_W-1:0] rgb_p1;
    logic              underflow_q;

    always_comb begin
        active = (hcnt_p0 < H_VIS) && (vcnt_p0 < V_VIS);
        flush  = (hcnt_p0 == 16'd0) && (vcnt_p0 == V_VIS);
        empty  = (wr_ptr == rd_ptr);
        // Pointers carry one wrap bit: equal index with differing wrap bit = full.
        full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        // Including reset keeps ready low while the block is held in reset.
        pix_ready    = !full && !flush && reset;
        push         = pix_valid && pix_ready;
        pop          = active && !empty;
        starve       = active && empty;
        vblank_start = flush && reset;
    end

    // Stage p0 -> p1: counters and FIFO advance, decoded outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_p0     <= '0;
            vcnt_p0     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            vld_p1      <= 1'b0;
            hsync_p1    <= 1'b1;
            vsync_p1    <= 1'b1;
            rgb_p1      <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (hcnt_p0 == H_LAST) begin
                hcnt_p0 <= '0;
                vcnt_p0 <= (vcnt_p0 == V_LAST) ? 16'd0 : vcnt_p0 + 16'd1;
            end else begin
                hcnt_p0 <= hcnt_p0 + 16'd1;
            end

            // Flush drops everything buffered so a PPU that fell behind
            // restarts aligned with the next frame.
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            vld_p1   <= active;
            hsync_p1 <= !((hcnt_p0 >= HS_BEG) && (hcnt_p0 < HS_END));
            vsync_p1 <= !((vcnt_p0 >= VS_BEG) && (vcnt_p0 < VS_END));
            rgb_p1   <= pop ? mem[rd_ptr[AW-1:0]] : '0;

            if (starve) begin
                underflow_q <= 1'b1;
            end else if (clear_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= pix_data;
        end
    end

    assign hpos       = hcnt_p0;
    assign vpos       = vcnt_p0;
    assign display_on = vld_p1;
    assign hsync      = hsync_p1;
    assign vsync      = vsync_p1;
    assign rgb        = rgb_p1;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout using a shrunk raster (24 x 10 clocks per frame) so
// every frame-level behaviour fits in a short run. A reference model updated
// on each clock edge holds the expected FIFO contents in a queue and the
// expected registered outputs; a negedge monitor compares the DUT against it
// every cycle, and a directed sequence measures sync widths, pulse spacing,
// fill depth, underflow and mid-frame reset.
module tb_video_scanout;

    localparam int HD = 16, HF = 2, HS = 4, HB = 2;
    localparam int VD = 6,  VF = 1, VS = 2, VB = 1;
    localparam int DEPTH = 16;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [12:0] pix_data = '0;
    logic        clear_underflow = 1'b0;
    logic        pix_ready;
    logic [15:0] hpos;
    logic [15:0] vpos;
    logic        display_on;
    logic        hsync;
    logic        vsync;
    logic [12:0] rgb;
    logic        vblank_start;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    video_scanout #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .FIFO_DEPTH(DEPTH), .DATA_W(13)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .vblank_start(vblank_start),
        .underflow(underflow), .clear_underflow(clear_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected pixel queue plus expected registered outputs.
    logic [12:0] mq[$];
    int          mh = 0;
    int          mv = 0;
    logic        e_disp = 1'b0;
    logic        e_hs = 1'b1;
    logic        e_vs = 1'b1;
    logic [12:0] e_rgb = '0;
    logic        e_uf = 1'b0;

    always @(posedge clk or negedge reset) begin
        logic m_act, m_fl, m_rdy;
        if (!reset) begin
            mh = 0; mv = 0; mq.delete();
            e_disp = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0; e_uf = 1'b0;
        end else begin
            m_act = (mh < HD) && (mv < VD);
            m_fl  = (mh == 0) && (mv == VD);
            m_rdy = (mq.size() < DEPTH) && !m_fl;
            if (m_act && mq.size() == 0) e_uf = 1'b1;
            else if (clear_underflow)    e_uf = 1'b0;
            e_rgb = '0;
            if (m_act && mq.size() > 0) e_rgb = mq.pop_front();
            if (m_fl) mq.delete();
            if (pix_valid && m_rdy) mq.push_back(pix_data);
            e_disp = m_act;
            e_hs = !((mh >= HD + HF) && (mh < HD + HF + HS));
            e_vs = !((mv >= VD + VF) && (mv < VD + VF + VS));
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("hpos", 32'(hpos), 32'(mh));
        check("vpos", 32'(vpos), 32'(mv));
        check("display_on", 32'(display_on), 32'(e_disp));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("underflow", 32'(underflow), 32'(e_uf));
        check("pix_ready", 32'(pix_ready),
              32'(reset && (mq.size() < DEPTH) && !(mh == 0 && mv == VD)));
        check("vblank_start", 32'(vblank_start), 32'(reset && mh == 0 && mv == VD));
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_hpos"}, 32'(hpos), 0);
        check({tag, "_vpos"}, 32'(vpos), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_disp"}, 32'(display_on), 0);
        check({tag, "_rgb"}, 32'(rgb), 0);
        check({tag, "_vblank"}, 32'(vblank_start), 0);
        check({tag, "_uf"}, 32'(underflow), 0);
        check({tag, "_ready"}, 32'(pix_ready), 0);
    endtask

    // Returns at negedge+1 of the vblank_start cycle; cnt = cycles waited.
    task automatic wait_vblank(input int max, output int cnt);
        bit found = 0;
        cnt = 0;
        while (!found && cnt < max) begin
            @(negedge clk); #1;
            cnt++;
            if (vblank_start) found = 1;
        end
        check("vblank_wait", 32'(found), 1);
    endtask

    initial begin
        int lows, first_low, vlows, vb_cnt, vb_pos, n, wcnt, seen, cnt, g;
        logic acc;
        bit hit;

        // Reset held
        repeat (3) @(negedge clk);
        #1 check_reset_values("rst");
        #1 reset = 1'b1;

        // Frame 1: no pixels, measure sync timing and vblank position
        lows = 0; first_low = 0; vlows = 0; vb_cnt = 0; vb_pos = 0;
        for (int k = 1; k <= FT; k++) begin
            @(negedge clk); #1;
            if (k <= HT && !hsync) begin
                lows++;
                if (first_low == 0) first_low = k;
            end
            if (k == HT) check("h_wrap", 32'(hpos), 0);
            if (!vsync) vlows++;
            if (vblank_start) begin vb_cnt++; vb_pos = k; end
        end
        check("hsync_low_len", 32'(lows), HS);
        check("hsync_fall", 32'(first_low), HD + HF + 1);
        check("vsync_low_len", 32'(vlows), VS * HT);
        check("vblank_once", 32'(vb_cnt), 1);
        check("vblank_pos", 32'(vb_pos), VD * HT);

        // Frame 2 vblank: spacing, then fill the FIFO
        wait_vblank(2 * FT, wcnt);
        check("vblank_period", 32'(FT - vb_pos + wcnt), FT);
        check("flush_ready_low", 32'(pix_ready), 0);
        n = 0;
        pix_valid = 1'b1;
        pix_data = 13'(n);
        acc = pix_ready;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); if (acc) n++;
            @(negedge clk); pix_data = 13'(n); #1 acc = pix_ready;
            if (!acc) break;
        end
        check("fill_accepts", 32'(n), DEPTH);

        // Keep streaming through frame 3 up to its flush
        seen = 0; hit = 0;
        for (int i = 0; i < 2 * FT && !hit; i++) begin
            @(posedge clk); if (acc) n++;
            @(negedge clk); pix_data = 13'(n); #1 acc = pix_ready;
            if (display_on && seen < 3) begin
                check("first_pixels", 32'(rgb), 32'(seen));
                seen++;
            end
            if (vblank_start) hit = 1;
        end
        check("stream_reached_flush", 32'(hit), 1);
        check("flush_blocks_push", 32'(pix_ready), 0);
        @(negedge clk); #1;
        check("ready_after_flush", 32'(pix_ready), 1);

        // Frame 4: only 10 pixels, expect underflow after them
        cnt = 0; g = 0;
        pix_data = 13'd100;
        acc = pix_ready;
        while (cnt < 10 && g < 40) begin
            @(posedge clk); if (acc) cnt++;
            @(negedge clk);
            if (cnt == 10) pix_valid = 1'b0;
            pix_data = 13'(100 + cnt);
            #1 acc = pix_ready;
            g++;
        end
        check("ten_accepted", 32'(cnt), 10);
        clear_underflow = 1'b1;
        @(negedge clk); clear_underflow = 1'b0;
        #1 check("uf_cleared_vblank", 32'(underflow), 0);
        hit = 0;
        for (int i = 0; i < FT && !hit; i++) begin
            @(negedge clk); #1;
            if (display_on) hit = 1;
        end
        check("line0_reached", 32'(hit), 1);
        for (int j = 0; j < 12; j++) begin
            check("ten_pixels", 32'(rgb), (j < 10) ? 32'(100 + j) : 0);
            @(negedge clk); #1;
        end
        check("uf_set", 32'(underflow), 1);
        wait_vblank(2 * FT, wcnt);
        check("uf_sticky", 32'(underflow), 1);
        clear_underflow = 1'b1;
        @(negedge clk); clear_underflow = 1'b0;
        #1 check("uf_clear_pulse", 32'(underflow), 0);

        // Frame 5: full FIFO, then asynchronous reset mid-frame
        pix_valid = 1'b1;
        pix_data = 13'd7;
        hit = 0;
        for (int i = 0; i < 2 * FT && !hit; i++) begin
            @(negedge clk); #1;
            if (hpos == 16'(HD + 2) && vpos == 16'd3) hit = 1;
        end
        check("reached_mid_frame", 32'(hit), 1);
        check("full_before_reset", 32'(pix_ready), 0);
        #1 reset = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        check("restart_hpos0", 32'(hpos), 0);
        @(negedge clk); #1;
        check("restart_hpos1", 32'(hpos), 1);
        check("restart_vpos", 32'(vpos), 0);
        check("restart_empty_ready", 32'(pix_ready), 1);
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
